word_tx_pacer: RTL and testbench

//  Upstream feeder for the UART transceiver's send port. Buffers 16-bit words from the core,

---
 rtl/word_tx_pacer_pkg.sv | 23 ++
 rtl/word_tx_pacer_if.sv | 21 ++
 rtl/word_tx_pacer_fifo.sv | 52 +++++
 rtl/word_tx_pacer.sv | 103 ++++++++++
 tb/tb_word_tx_pacer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/word_tx_pacer_pkg.sv
// Shared types and UART timing constants for the word pacer.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    CSUM = 2'd2
  } tx_pacer_state_t;

  localparam int BITS_PER_UART_FRAME = 10;
  localparam int BYTES_PER_WORD      = 2;
  localparam int UART_CLKS_PER_BIT   = 434;
  localparam int GAP_MARGIN_CYCLES   = 120;
  // Two full UART frames plus slack so the transceiver is always done before the next word.
  localparam int DEFAULT_GAP_CYCLES  =
    BYTES_PER_WORD * BITS_PER_UART_FRAME * UART_CLKS_PER_BIT + GAP_MARGIN_CYCLES;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } tx_word_t;

endpackage

// File: rtl/word_tx_pacer_if.sv
// Core-side word bus plus transceiver send port and status of the pacer.
interface word_tx_pacer_if #(parameter int DEPTH = 8);
  logic [15:0]            in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [15:0]            data_send;
  logic                   data_send_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   busy;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, data_send, data_send_valid, fifo_count, busy
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, data_send, data_send_valid, fifo_count, busy
  );
endinterface

// File: rtl/word_tx_pacer_fifo.sv
// Synchronous FIFO; pop on empty and push on full are ignored.
module word_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/word_tx_pacer.sv
// Buffers core words and issues them to the UART transceiver at a fixed pace,
// optionally following each packet with a 16-bit wrap-around checksum word.
module word_tx_pacer
  import link_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int CSUM_EN    = 1
) (
  input  logic            clk,
  input  logic            rst,
  word_tx_pacer_if.slave  bus
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  tx_pacer_state_t state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [15:0]     csum_q, csum_d;
  logic            pend_q, pend_d;
  logic [15:0]     ds_q, ds_d;
  logic            dsv_q, dsv_d;

  tx_word_t        head;
  logic            full, empty, push, pop;
  logic [CW-1:0]   count;

  assign bus.in_ready = !rst && !full;
  assign push         = bus.in_valid && bus.in_ready;
  // The FIFO is only drained from IDLE, so the gap is never shortened by a backlog.
  assign pop          = (state_q == IDLE) && !empty;

  word_fifo #(.WIDTH($bits(tx_word_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.in_last, bus.in_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Next-state logic: issue a word or checksum, then count out the gap.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    csum_d  = csum_q;
    pend_d  = pend_q;
    ds_d    = ds_q;
    dsv_d   = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        ds_d    = head.data;
        dsv_d   = 1'b1;
        csum_d  = csum_q + head.data;
        pend_d  = head.last && (CSUM_EN != 0);
        if (head.last && (CSUM_EN == 0)) csum_d = '0;
        gap_d   = GAP_LOAD;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) state_d = pend_q ? CSUM : IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      CSUM: begin
        ds_d    = csum_q;
        dsv_d   = 1'b1;
        csum_d  = '0;
        pend_d  = 1'b0;
        gap_d   = GAP_LOAD;
        state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any gap and pending checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      csum_q  <= '0;
      pend_q  <= 1'b0;
      ds_q    <= '0;
      dsv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      csum_q  <= csum_d;
      pend_q  <= pend_d;
      ds_q    <= ds_d;
      dsv_q   <= dsv_d;
    end
  end

  assign bus.data_send       = ds_q;
  assign bus.data_send_valid = dsv_q;
  assign bus.fifo_count      = count;
  assign bus.busy            = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_word_tx_pacer.sv
// Scoreboard bench: accepted words feed a packet-level reference model whose
// expected issue stream is checked by a monitor on every send pulse.
module tb_word_tx_pacer;
  localparam int GAP = 8;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  word_tx_pacer_if #(.DEPTH(DEP)) b0 ();
  word_tx_pacer_if #(.DEPTH(DEP)) b1 ();

  word_tx_pacer #(.DEPTH(DEP), .GAP_CYCLES(GAP), .CSUM_EN(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  word_tx_pacer #(.DEPTH(DEP), .GAP_CYCLES(GAP), .CSUM_EN(0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // Reference state: expected issue streams, running sums, pulse/accept timestamps.
  logic [15:0] expq0[$], expq1[$];
  int          pc0[$], pc1[$], hc0[$], hc1[$];
  logic [15:0] msum[2];
  logic [15:0] hold[2];
  int          lastp[2];
  int          maxfc[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic dsv, input logic [15:0] ds, input logic v,
                     input logic r, input logic [15:0] d, input logic l,
                     input logic [2:0] fc, input logic rs);
    logic [15:0] e;
    int sz;
    if (dsv) begin
      if (k == 0) pc0.push_back(cyc); else pc1.push_back(cyc);
      sz = (k == 0) ? expq0.size() : expq1.size();
      if (sz == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse[%0d]: got %h, nothing expected", k, ds);
      end else begin
        e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
        chk($sformatf("pulse_value[%0d]", k), ds, e);
      end
      if (lastp[k] >= 0) begin
        checks++;
        if (cyc - lastp[k] < GAP + 1) begin
          errors++;
          $display("FAIL pulse_spacing[%0d]: got %0d, expected >= %0d", k, cyc - lastp[k], GAP + 1);
        end
      end
      lastp[k] = cyc;
      hold[k]  = ds;
    end else begin
      chk($sformatf("data_send_hold[%0d]", k), ds, hold[k]);
    end
    if (int'(fc) > maxfc[k]) maxfc[k] = int'(fc);
    if (fc == 3'(DEP)) chk($sformatf("in_ready_when_full[%0d]", k), r, 1'b0);
    if (v && r) begin
      if (k == 0) hc0.push_back(cyc); else hc1.push_back(cyc);
      msum[k] = msum[k] + d;
      if (k == 0) expq0.push_back(d); else expq1.push_back(d);
      if (l) begin
        if (k == 0) expq0.push_back(msum[k]);
        msum[k] = '0;
      end
    end
    if (rs) begin
      if (k == 0) expq0.delete(); else expq1.delete();
      msum[k]  = '0;
      hold[k]  = '0;
      lastp[k] = -1;
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.data_send_valid, b0.data_send, b0.in_valid, b0.in_ready, b0.in_data, b0.in_last, b0.fifo_count, rst);
    mon(1, b1.data_send_valid, b1.data_send, b1.in_valid, b1.in_ready, b1.in_data, b1.in_last, b1.fifo_count, rst);
  end

  // Called at posedge+1; holds in_valid until the handshake, returns at posedge+1.
  task automatic send(input int k, input logic [15:0] d, input logic l);
    int n = 0;
    logic r;
    if (k == 0) begin b0.in_data = d; b0.in_last = l; b0.in_valid = 1'b1; end
    else        begin b1.in_data = d; b1.in_last = l; b1.in_valid = 1'b1; end
    do begin
      @(negedge clk);
      n++;
      r = (k == 0) ? b0.in_ready : b1.in_ready;
    end while (!r && n < 500);
    if (!r) begin
      checks++; errors++;
      $display("FAIL send_timeout[%0d]: in_ready never rose in %0d cycles", k, n);
    end
    @(posedge clk); #1;
    if (k == 0) b0.in_valid = 1'b0; else b1.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    logic pend;
    do begin
      @(negedge clk);
      n++;
      pend = (k == 0) ? (expq0.size() != 0 || b0.busy) : (expq1.size() != 0 || b1.busy);
    end while (pend && n < 400);
    chk($sformatf("drain_timeout[%0d]", k), pend, 1'b0);
    chk($sformatf("idle_busy[%0d]", k), (k == 0) ? b0.busy : b1.busy, 1'b0);
    chk($sformatf("idle_count[%0d]", k), (k == 0) ? b0.fifo_count : b1.fifo_count, 3'd0);
    @(posedge clk); #1;
  endtask

  // Backlogged run on instance 0: first pulse at accept+2, then exactly GAP+1 apart.
  task automatic check_timing(input int n);
    chk("pulse_count", pc0.size(), n);
    if (pc0.size() == n && hc0.size() > 0) begin
      chk("first_latency", pc0[0] - hc0[0], 2);
      for (int i = 1; i < n; i++) chk($sformatf("spacing_%0d", i), pc0[i] - pc0[i-1], GAP + 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin msum[k] = '0; hold[k] = '0; lastp[k] = -1; maxfc[k] = 0; end
    b0.in_data = '0; b0.in_valid = 1'b0; b0.in_last = 1'b0;
    b1.in_data = '0; b1.in_valid = 1'b0; b1.in_last = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready0", b0.in_ready, 1'b0);
    chk("rst_in_ready1", b1.in_ready, 1'b0);
    chk("rst_dsv", b0.data_send_valid, 1'b0);
    chk("rst_data_send", b0.data_send, 16'h0);
    chk("rst_count", b0.fifo_count, 3'd0);
    chk("rst_busy", b0.busy, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", b0.in_ready, 1'b1);
    chk("rel_busy", b0.busy, 1'b0);
    @(posedge clk); #1;

    // Single-word packet: word then checksum equal to that word
    pc0.delete(); hc0.delete();
    send(0, 16'h1234, 1'b1);
    wait_idle(0);
    check_timing(2);

    // Burst with wrap-around checksum
    pc0.delete(); hc0.delete();
    send(0, 16'hFFFF, 1'b0);
    send(0, 16'h0002, 1'b0);
    send(0, 16'h0010, 1'b1);
    wait_idle(0);
    check_timing(4);

    // Overfill a DEPTH=4 FIFO
    pc0.delete(); hc0.delete(); maxfc[0] = 0;
    for (int i = 0; i < 6; i++) send(0, 16'h0100 + 16'(i), i == 5);
    wait_idle(0);
    check_timing(7);
    chk("max_fifo_count", maxfc[0], DEP);

    // No checksum instance, two single-word packets
    pc1.delete(); hc1.delete();
    send(1, 16'h00AA, 1'b1);
    send(1, 16'h00BB, 1'b1);
    wait_idle(1);
    chk("nocsum_pulses", pc1.size(), 2);
    if (pc1.size() == 2 && hc1.size() > 0) begin
      chk("nocsum_latency", pc1[0] - hc1[0], 2);
      chk("nocsum_spacing", pc1[1] - pc1[0], GAP + 1);
    end

    // Reset during a gap with two words still queued
    pc0.delete();
    send(0, 16'hA1A1, 1'b0);
    send(0, 16'hB2B2, 1'b0);
    send(0, 16'hC3C3, 1'b0);
    n = 0;
    while (pc0.size() == 0 && n < 100) begin @(negedge clk); n++; end
    chk("pre_reset_pulse_seen", pc0.size() != 0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_count", b0.fifo_count, 3'd0);
    chk("midrst_dsv", b0.data_send_valid, 1'b0);
    chk("midrst_busy", b0.busy, 1'b0);
    @(posedge clk); #1;
    send(0, 16'h0005, 1'b1);
    wait_idle(0);

    // Randomized traffic on both instances
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #0;
        send(0, 16'($urandom), ($urandom_range(0, 3) == 0) || i == 24);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #0;
        send(1, 16'($urandom), ($urandom_range(0, 3) == 0) || j == 24);
      end
    join
    wait_idle(0);
    wait_idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
